// File: rtl/subs_layer_iter_if.sv
// Handshake bundle for the iterative substitution layer.
// Producer side drives in_*/out_ready, the layer drives in_ready/out_*.
interface subs_layer_iter_if #(
  parameter int SIZE = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] in_data;
  logic            in_decrypt;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out_data;

  modport master (
    output in_valid, in_data, in_decrypt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_decrypt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/subs_layer_iter.sv
// Iterative S-box substitution layer: one SIZE-bit word per transaction,
// LANES nibbles substituted per cycle, most significant nibbles first.
// Optional feature macro: SUBS_ENCRYPT_EN
//   defined   - forward and inverse tables, in_decrypt picks per transaction
//   undefined - inverse table only, in_decrypt is ignored
//
// state | meaning
// IDLE  | waiting for a word, in_ready=1
// BUSY  | substituting one lane group per cycle
// DONE  | result on out_data, out_valid=1, held until out_ready
module subs_layer_iter #(
  parameter int SIZE  = 64,
  parameter int LANES = 4
) (
  input logic             clk,
  input logic             rst,
  subs_layer_iter_if.slave bus
);

  localparam int NIB   = SIZE / 4;
  localparam int BEATS = NIB / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (SIZE != 64 && SIZE != 128) begin : g_bad_size
    $error("subs_layer_iter: SIZE must be 64 or 128");
  end
  if (LANES < 1 || (NIB % LANES) != 0) begin : g_bad_lanes
    $error("subs_layer_iter: LANES must divide SIZE/4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [SIZE-1:0] work, work_sub;
  logic [CW-1:0]   beat;
  logic            in_ready_c, out_valid_c;
  logic            accept;
  logic            last_beat;
`ifdef SUBS_ENCRYPT_EN
  logic            mode;
`endif

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

`ifdef SUBS_ENCRYPT_EN
  function automatic logic [3:0] fwd_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction
`endif

  // Nibble handled by lane l on beat b; beat 0 starts at the top nibble.
  function automatic int nib_idx(input logic [CW-1:0] b, input int l);
    return NIB - 1 - int'(b) * LANES - l;
  endfunction

  assign accept    = bus.in_valid && in_ready_c;
  assign last_beat = (beat == CW'(BEATS - 1));

  // Substitute the current lane group of the working register.
  always_comb begin
    work_sub = work;
    for (int l = 0; l < LANES; l++) begin
`ifdef SUBS_ENCRYPT_EN
      work_sub[nib_idx(beat, l)*4 +: 4] = mode ? inv_sbox(work[nib_idx(beat, l)*4 +: 4])
                                               : fwd_sbox(work[nib_idx(beat, l)*4 +: 4]);
`else
      work_sub[nib_idx(beat, l)*4 +: 4] = inv_sbox(work[nib_idx(beat, l)*4 +: 4]);
`endif
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: if (last_beat) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = bus.in_valid ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; in_ready also follows out_ready in DONE.
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: in_ready_c = 1'b1;
      DONE: begin
        out_valid_c = 1'b1;
        in_ready_c  = bus.out_ready;
      end
      default: ;
    endcase
  end

  // Working register, beat counter and mode: load on accept, step while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work <= '0;
      beat <= '0;
`ifdef SUBS_ENCRYPT_EN
      mode <= 1'b0;
`endif
    end else if (accept) begin
      work <= bus.in_data;
      beat <= '0;
`ifdef SUBS_ENCRYPT_EN
      mode <= bus.in_decrypt;
`endif
    end else if (state == BUSY) begin
      work <= work_sub;
      beat <= beat + CW'(1);
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = work;

endmodule

// File: tb/tb_subs_layer_iter.sv
// Directed bench for subs_layer_iter: vector table on a 64-bit/4-lane
// instance, hand sequences for backpressure and reset, plus a 128-bit sweep.
module tb_subs_layer_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  subs_layer_iter_if #(.SIZE(64))  bus ();
  subs_layer_iter_if #(.SIZE(128)) bus_l1 ();
  subs_layer_iter_if #(.SIZE(128)) bus_l4 ();
  subs_layer_iter_if #(.SIZE(128)) bus_l32 ();

  subs_layer_iter #(.SIZE(64),  .LANES(4))  dut     (.clk(clk), .rst(rst), .bus(bus.slave));
  subs_layer_iter #(.SIZE(128), .LANES(1))  dut_l1  (.clk(clk), .rst(rst), .bus(bus_l1.slave));
  subs_layer_iter #(.SIZE(128), .LANES(4))  dut_l4  (.clk(clk), .rst(rst), .bus(bus_l4.slave));
  subs_layer_iter #(.SIZE(128), .LANES(32)) dut_l32 (.clk(clk), .rst(rst), .bus(bus_l32.slave));

  typedef struct {
    logic [63:0] data;
    logic        dec;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Present a word on the 64-bit instance and step through its accepting edge.
  task automatic send(input logic [63:0] d, input logic dec);
    int w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("send_in_ready", {127'd0, bus.in_ready}, 128'd1);
    bus.in_valid   = 1'b1;
    bus.in_data    = d;
    bus.in_decrypt = dec;
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
    bus.in_data    = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.in_decrypt = ~dec;
  endtask

  // Count cycles after the accepting edge until out_valid, then check data.
  task automatic wait_result(input string name, input int exp_lat, input logic [63:0] exp);
    int cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk({name, "_latency"}, 128'(cyc), 128'(exp_lat));
    chk({name, "_data"}, {64'd0, bus.out_data}, {64'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] hold;
    logic        stable_ok, ready_ok, valid_ok, silent_ok;
    int lat1, lat4, lat32;
    logic [127:0] d1, d4, d32;

    vecs[0] = '{64'h0123456789ABCDEF, 1'b1, 64'h5EF8C12DB463079A};
    vecs[1] = '{64'h0000000000000000, 1'b1, 64'h5555555555555555};
    vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hAAAAAAAAAAAAAAAA};
    vecs[4] = '{64'hC56B90AD3EF84712, 1'b1, 64'h0123456789ABCDEF};
    vecs[5] = '{64'hFEDCBA9876543210, 1'b1, 64'hA970364BD21C8FE5};
`ifdef SUBS_ENCRYPT_EN
    vecs[3] = '{64'h0123456789ABCDEF, 1'b0, 64'hC56B90AD3EF84712};
    vecs[6] = '{64'h0000000000000000, 1'b0, 64'hCCCCCCCCCCCCCCCC};
`else
    vecs[3] = '{64'h0123456789ABCDEF, 1'b0, 64'h5EF8C12DB463079A};
    vecs[6] = '{64'h0000000000000000, 1'b0, 64'h5555555555555555};
`endif

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_decrypt = 1'b0; bus.out_ready = 1'b1;
    bus_l1.in_valid  = 1'b0; bus_l1.in_data  = '0; bus_l1.in_decrypt  = 1'b1; bus_l1.out_ready  = 1'b1;
    bus_l4.in_valid  = 1'b0; bus_l4.in_data  = '0; bus_l4.in_decrypt  = 1'b1; bus_l4.out_ready  = 1'b1;
    bus_l32.in_valid = 1'b0; bus_l32.in_data = '0; bus_l32.in_decrypt = 1'b1; bus_l32.out_ready = 1'b1;

    #12;
    chk("rst_in_ready",  {127'd0, bus.in_ready},  128'd1);
    chk("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("rst_out_data",  {64'd0, bus.out_data},   128'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Vector table on the 64-bit instance.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].data, vecs[i].dec);
      chk($sformatf("vec%0d_busy_in_ready", i), {127'd0, bus.in_ready}, 128'd0);
      wait_result($sformatf("vec%0d", i), 4, vecs[i].exp);
      @(posedge clk); #1;
    end

    // Backpressure: result held for 10 cycles, then back-to-back accept.
    bus.out_ready = 1'b0;
    send(64'h0123456789ABCDEF, 1'b1);
    wait_result("bp_first", 4, 64'h5EF8C12DB463079A);
    hold = bus.out_data;
    stable_ok = 1'b1; ready_ok = 1'b1; valid_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.out_data !== hold) stable_ok = 1'b0;
      if (bus.in_ready !== 1'b0) ready_ok = 1'b0;
      if (bus.out_valid !== 1'b1) valid_ok = 1'b0;
    end
    chk("bp_data_stable", {127'd0, stable_ok}, 128'd1);
    chk("bp_in_ready_low", {127'd0, ready_ok}, 128'd1);
    chk("bp_valid_held",  {127'd0, valid_ok}, 128'd1);
    bus.in_valid   = 1'b1;
    bus.in_data    = 64'hFEDCBA9876543210;
    bus.in_decrypt = 1'b1;
    bus.out_ready  = 1'b1;
    #1;
    chk("bp_in_ready_comb", {127'd0, bus.in_ready}, 128'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    chk("bp_b2b_busy_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("bp_b2b_busy_ready", {127'd0, bus.in_ready},  128'd0);
    wait_result("bp_second", 4, 64'hA970364BD21C8FE5);
    @(posedge clk); #1;

    // Reset on beat 2 aborts the word.
    send(64'h0123456789ABCDEF, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("rst_mid_out_data",  {64'd0, bus.out_data},   128'd0);
    chk("rst_mid_in_ready",  {127'd0, bus.in_ready},  128'd1);
    @(negedge clk); rst = 1'b0;
    silent_ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) silent_ok = 1'b0;
    end
    chk("rst_mid_no_output", {127'd0, silent_ok}, 128'd1);
    send(64'hFFFFFFFFFFFFFFFF, 1'b1);
    wait_result("rst_mid_fresh", 4, 64'hAAAAAAAAAAAAAAAA);
    @(posedge clk); #1;

    // Reset while a result is waiting drops out_valid without a clock edge.
    bus.out_ready = 1'b0;
    send(64'h0000000000000000, 1'b1);
    wait_result("rst_done_pre", 4, 64'h5555555555555555);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_done_out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("rst_done_out_data",  {64'd0, bus.out_data},   128'd0);
    @(negedge clk); rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    // 128-bit sweep, all three instances started on the same edge.
    bus_l1.in_valid  = 1'b1; bus_l1.in_data  = {128{1'b1}};
    bus_l4.in_valid  = 1'b1; bus_l4.in_data  = {128{1'b1}};
    bus_l32.in_valid = 1'b1; bus_l32.in_data = {128{1'b1}};
    #1;
    chk("sweep_l1_in_ready",  {127'd0, bus_l1.in_ready},  128'd1);
    @(posedge clk); #1;
    bus_l1.in_valid = 1'b0; bus_l4.in_valid = 1'b0; bus_l32.in_valid = 1'b0;
    lat1 = -1; lat4 = -1; lat32 = -1;
    d1 = '0; d4 = '0; d32 = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1 || 1) begin
        @(posedge clk); #1;
      end
      if (lat1  < 0 && bus_l1.out_valid)  begin lat1  = c; d1  = bus_l1.out_data;  end
      if (lat4  < 0 && bus_l4.out_valid)  begin lat4  = c; d4  = bus_l4.out_data;  end
      if (lat32 < 0 && bus_l32.out_valid) begin lat32 = c; d32 = bus_l32.out_data; end
    end
    chk("sweep_l1_latency",  128'(lat1),  128'd32);
    chk("sweep_l4_latency",  128'(lat4),  128'd8);
    chk("sweep_l32_latency", 128'(lat32), 128'd1);
    chk("sweep_l1_data",  d1,  {32{4'hA}});
    chk("sweep_l4_data",  d4,  {32{4'hA}});
    chk("sweep_l32_data", d32, {32{4'hA}});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/subs_layer_iter.md
# subs_layer_iter

Iterative, parametrised S-box substitution layer for the block-cipher datapath. It accepts one SIZE-bit state word per transaction, substitutes its 4-bit nibbles LANES at a time over several cycles, and returns the substituted word. The mode (inverse or forward S-box) is selected per transaction. It sits between the round-key XOR and the permutation layer in both the encrypt and decrypt round engines. A valid/ready handshake on each side lets the round controller stall it.

## Interface
Parameters:
- SIZE, 64: state width in bits; legal values are 64 and 128.
- LANES, 4: nibbles substituted per cycle; must divide SIZE/4.
- BEATS (localparam): SIZE/(4*LANES), the number of substitution cycles.

Ports:
- clk  input  1  clock; all state is updated on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data and in_decrypt are valid.
- in_ready  output  1  the block can accept a word.
- in_data  input  SIZE  state word to substitute.
- in_decrypt  input  1  mode select: 1 = inverse S-box, 0 = forward S-box.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  the consumer accepts out_data.
- out_data  output  SIZE  substituted word.

## Operation
- Forward S-box, nibble value 0..F maps to: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- Inverse S-box, nibble value 0..F maps to: 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
- Nibble i occupies bits [4i+3:4i].
- Processing order runs from the most significant nibble down:
  - beat 0 substitutes nibbles SIZE/4-1 down to SIZE/4-LANES;
  - each later beat takes the next LANES nibbles below.
- Accept condition: in_valid && in_ready.
  - On accept, in_data is loaded into the working register and in_decrypt into the mode register.
  - Both are held for the whole transaction; input changes after acceptance have no effect.
- FSM states:
  - IDLE: in_ready=1. On accept, go to BUSY and clear the beat counter.
  - BUSY: each cycle, substitute the current lane group in place and increment the beat counter. On beat BEATS-1, go to DONE.
  - DONE: out_valid=1 and out_data is stable.
    - If out_ready=1 and in_valid=0, go to IDLE.
    - If out_ready=1 and in_valid=1, the new word is accepted in the same cycle and the FSM goes to BUSY.
    - If out_ready=0, stay in DONE with out_data held.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from state and out_ready.
- The beat counter is $clog2(BEATS) bits wide, with a minimum of 1 bit. It never wraps during a transaction, because exit occurs at BEATS-1.
- out_data equals the working register and is meaningful only while out_valid=1.

## Timing
- Reset values:
  - state = IDLE;
  - in_ready = 1;
  - out_valid = 0;
  - out_data = 0;
  - beat counter = 0;
  - mode = 0.
- Latency: out_valid rises exactly BEATS cycles after the accepting edge. With SIZE=64 and LANES=4 this is 4 cycles; with LANES=SIZE/4 it is 1 cycle.
- Throughput: one word every BEATS+1 cycles when out_ready is held at 1, including the back-to-back accept in DONE.
- Asserting rst mid-transaction aborts it immediately:
  - out_valid drops asynchronously;
  - the partial result is discarded;
  - no output is ever produced for the aborted word.
- in_valid while BUSY is ignored and in_ready=0; the producer must hold the word.

## Configuration
- SUBS_ENCRYPT_EN defined:
  - both tables are compiled in;
  - in_decrypt selects the table per transaction.
- SUBS_ENCRYPT_EN undefined:
  - only the inverse S-box is built;
  - in_decrypt is ignored, and every transaction uses the inverse table;
  - port list and timing are unchanged.

## Test plan
- Decrypt: SIZE=64, LANES=4, in_decrypt=1, in_data=0x0123456789ABCDEF -> out_data=0x5EF8C12DB463079A, with out_valid rising 4 cycles after accept.
- Encrypt (SUBS_ENCRYPT_EN defined): in_decrypt=0, same input -> 0xC56B90AD3EF84712. Feeding that result back with in_decrypt=1 -> 0x0123456789ABCDEF.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid:
  - out_data stays stable and in_ready stays 0;
  - raising out_ready with in_valid=1 accepts the next word in the same cycle.
- Reset mid-operation: assert rst on beat 2:
  - out_valid=0, out_data=0 and in_ready=1 immediately;
  - a fresh word afterwards completes correctly.
- Parameter sweep: for SIZE=128 with LANES=1, 4, 32, an all-0xF input with in_decrypt=1 -> all-0xA output, with latency 32, 8 and 1 cycles respectively.
- Macro off: with SUBS_ENCRYPT_EN undefined, in_decrypt=0 and in_data=0x0123456789ABCDEF -> 0x5EF8C12DB463079A.
